// File: rtl/seg7_scan_capture_pkg.sv
// Shared 7-segment definitions: glyph patterns (active-low, G..A) and capture FSM encodings.
// Pure constants and helpers; no latency, no flow control.
// The drive-side decoder imports the same glyph table so the two ends cannot drift.
package seg7_scan_capture_pkg;

   localparam logic [6:0] SEG_0 = 7'h40;
   localparam logic [6:0] SEG_1 = 7'h79;
   localparam logic [6:0] SEG_2 = 7'h24;
   localparam logic [6:0] SEG_3 = 7'h30;
   localparam logic [6:0] SEG_4 = 7'h19;
   localparam logic [6:0] SEG_5 = 7'h12;
   localparam logic [6:0] SEG_6 = 7'h02;
   localparam logic [6:0] SEG_7 = 7'h78;
   localparam logic [6:0] SEG_8 = 7'h00;
   localparam logic [6:0] SEG_9 = 7'h10;
   localparam logic [6:0] SEG_A = 7'h08;
   localparam logic [6:0] SEG_B = 7'h03;
   localparam logic [6:0] SEG_C = 7'h46;
   localparam logic [6:0] SEG_D = 7'h21;
   localparam logic [6:0] SEG_E = 7'h06;
   localparam logic [6:0] SEG_F = 7'h0E;

   localparam logic [1:0] SCAN   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] HELD   = 2'd2;

   // {valid, index}: valid only when exactly one anode is driven low
   function automatic logic [2:0] an_select(input logic [3:0] an_n);
      logic [2:0] r;
      case (an_n)
         4'b1110: r = 3'b100;
         4'b1101: r = 3'b101;
         4'b1011: r = 3'b110;
         4'b0111: r = 3'b111;
         default: r = 3'b000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Segment pattern to hex nibble; flags patterns that are not one of the 16 glyphs.
// Combinational, zero latency; no flow control.
// Illegal patterns decode to nibble 0 with legal low.
module seg7_pattern_decode
   import seg7_scan_capture_pkg::*;
(
   input  logic [6:0] seg_n,
   output logic [3:0] nibble,
   output logic       legal
);

   always_comb begin
      nibble = 4'h0;
      legal  = 1'b1;
      case (seg_n)
         SEG_0: nibble = 4'h0;
         SEG_1: nibble = 4'h1;
         SEG_2: nibble = 4'h2;
         SEG_3: nibble = 4'h3;
         SEG_4: nibble = 4'h4;
         SEG_5: nibble = 4'h5;
         SEG_6: nibble = 4'h6;
         SEG_7: nibble = 4'h7;
         SEG_8: nibble = 4'h8;
         SEG_9: nibble = 4'h9;
         SEG_A: nibble = 4'hA;
         SEG_B: nibble = 4'hB;
         SEG_C: nibble = 4'hC;
         SEG_D: nibble = 4'hD;
         SEG_E: nibble = 4'hE;
         SEG_F: nibble = 4'hF;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_capture.sv
// Reconstructs the 16-bit value shown on a multiplexed 4-digit common-anode display.
// Latency: pins stable STABLE_CYCLES+1 edges -> capture; frame_valid one cycle after 4th digit.
// No backpressure: passive monitor, outputs simply update per completed frame.
module seg7_scan_capture
   import seg7_scan_capture_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  an_n,
   input  logic [6:0]  seg_n,
   output logic [15:0] value,
   output logic [3:0]  digit_err,
   output logic        frame_valid,
   output logic        busy
);

   localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

   logic [3:0]  s_an, p_an;
   logic [6:0]  s_seg, p_seg;
   logic [1:0]  state, state_nxt;
   logic [7:0]  cnt, cnt_nxt;
   logic [3:0]  mask, mask_nxt;
   logic [15:0] shadow;
   logic [3:0]  err_shadow;

   logic [2:0]  sel;
   logic        dig_vld;
   logic [1:0]  dig_idx;
   logic        changed;
   logic        capture;
   logic [3:0]  cap_bit;
   logic        frame_done;
   logic [3:0]  nibble;
   logic        legal;

   seg7_pattern_decode u_decode (
      .seg_n  (s_seg),
      .nibble (nibble),
      .legal  (legal)
   );

   assign sel        = an_select(s_an);
   assign dig_vld    = sel[2];
   assign dig_idx    = sel[1:0];
   assign changed    = (s_an != p_an) || (s_seg != p_seg);
   assign capture    = (state == SETTLE) && !changed && (cnt == STABLE_CNT);
   assign cap_bit    = capture ? (4'b0001 << dig_idx) : 4'b0000;
   assign frame_done = (mask == 4'b1111);
   // A capture landing on the completion edge belongs to the next frame
   assign mask_nxt   = frame_done ? cap_bit : (mask | cap_bit);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         SCAN: begin
            if (dig_vld) begin
               state_nxt = SETTLE;
               cnt_nxt   = 8'd1;
            end
         end
         SETTLE: begin
            if (changed) begin
               if (dig_vld) cnt_nxt = 8'd1;
               else         state_nxt = SCAN;
            end else if (cnt == STABLE_CNT) begin
               state_nxt = HELD;
            end else if (cnt != 8'hFF) begin
               cnt_nxt = cnt + 8'd1;
            end
         end
         HELD: begin
            if (changed) begin
               if (dig_vld) begin
                  state_nxt = SETTLE;
                  cnt_nxt   = 8'd1;
               end else begin
                  state_nxt = SCAN;
               end
            end
         end
         default: state_nxt = SCAN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_an        <= 4'h0;
         s_seg       <= 7'h00;
         p_an        <= 4'h0;
         p_seg       <= 7'h00;
         state       <= SCAN;
         cnt         <= 8'd0;
         mask        <= 4'h0;
         shadow      <= 16'h0000;
         err_shadow  <= 4'h0;
         value       <= 16'h0000;
         digit_err   <= 4'h0;
         frame_valid <= 1'b0;
         busy        <= 1'b0;
      end else begin
         s_an        <= an_n;
         s_seg       <= seg_n;
         p_an        <= s_an;
         p_seg       <= s_seg;
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         mask        <= mask_nxt;
         busy        <= |mask_nxt;
         frame_valid <= frame_done;
         if (frame_done) begin
            value     <= shadow;
            digit_err <= err_shadow;
         end
         if (capture) begin
            shadow[{dig_idx, 2'b00} +: 4] <= legal ? nibble : 4'h0;
            err_shadow[dig_idx]           <= ~legal;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: hand-computed frames, glitches, illegal glyphs, resets.
module tb_seg7_scan_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic [15:0] value;
   logic [3:0]  digit_err;
   logic        frame_valid;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fv_count = 0;
   int fv_cyc = -1;
   int start3;
   int fv_base;
   logic busy_seen;

   seg7_scan_capture #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .an_n        (an_n),
      .seg_n       (seg_n),
      .value       (value),
      .digit_err   (digit_err),
      .frame_valid (frame_valid),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         fv_count++;
         fv_cyc = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
      an_n  = a;
      seg_n = s;
      repeat (n) @(negedge clk);
   endtask

   // digits 0..3 in scan order E, D, B, 7, then blank
   task automatic scan4(input logic [6:0] g0, input logic [6:0] g1,
                        input logic [6:0] g2, input logic [6:0] g3);
      drive(4'hE, g0, 8);
      drive(4'hD, g1, 8);
      drive(4'hB, g2, 8);
      start3 = cyc;
      drive(4'h7, g3, 8);
      drive(4'hF, 7'h7F, 6);
   endtask

   initial begin
      rst   = 1'b1;
      an_n  = 4'hF;
      seg_n = 7'h7F;
      repeat (3) @(negedge clk);
      chk("reset_value", 32'(value), 32'h0);
      chk("reset_err", 32'(digit_err), 32'h0);
      chk("reset_fv", 32'(frame_valid), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      rst = 1'b0;
      drive(4'hF, 7'h7F, 3);

      // basic frame "3210"
      fv_base = fv_count;
      drive(4'hE, 7'h40, 8);
      chk("busy_after_d0", 32'(busy), 32'h1);
      drive(4'hD, 7'h79, 8);
      drive(4'hB, 7'h24, 8);
      start3 = cyc;
      drive(4'h7, 7'h30, 8);
      drive(4'hF, 7'h7F, 6);
      chk("basic_value", 32'(value), 32'h3210);
      chk("basic_err", 32'(digit_err), 32'h0);
      chk("basic_fv_once", 32'(fv_count - fv_base), 32'h1);
      chk("basic_fv_latency", 32'(fv_cyc), 32'(start3 + 7));
      chk("basic_busy_idle", 32'(busy), 32'h0);

      // digit 1 glitches through A for 3 cycles before settling on b
      fv_base = fv_count;
      drive(4'hE, 7'h40, 8);
      drive(4'hD, 7'h08, 3);
      drive(4'hD, 7'h03, 6);
      drive(4'hB, 7'h24, 8);
      drive(4'h7, 7'h30, 8);
      drive(4'hF, 7'h7F, 6);
      chk("glitch_value", 32'(value), 32'h32B0);
      chk("glitch_fv_once", 32'(fv_count - fv_base), 32'h1);

      // blank glyph on digit 2
      fv_base = fv_count;
      scan4(7'h0E, 7'h06, 7'h7F, 7'h46);
      chk("illegal_value", 32'(value), 32'hC0EF);
      chk("illegal_err", 32'(digit_err), 32'h4);
      chk("illegal_fv_latency", 32'(fv_cyc), 32'(start3 + 7));

      // two anodes low: never an active digit
      fv_base = fv_count;
      busy_seen = 1'b0;
      an_n  = 4'b1100;
      seg_n = 7'h40;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         busy_seen = busy_seen | busy;
      end
      drive(4'hF, 7'h7F, 4);
      chk("multi_low_busy", 32'(busy_seen), 32'h0);
      chk("multi_low_no_fv", 32'(fv_count - fv_base), 32'h0);
      chk("multi_low_value", 32'(value), 32'hC0EF);

      // reset mid-frame discards partial capture
      drive(4'hE, 7'h40, 8);
      drive(4'hD, 7'h79, 8);
      chk("pre_reset_busy", 32'(busy), 32'h1);
      fv_base = fv_count;
      rst  = 1'b1;
      an_n = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_reset_busy", 32'(busy), 32'h0);
      chk("mid_reset_value", 32'(value), 32'h0);
      chk("mid_reset_err", 32'(digit_err), 32'h0);
      drive(4'hF, 7'h7F, 3);
      scan4(7'h40, 7'h79, 7'h24, 7'h30);
      chk("post_reset_value", 32'(value), 32'h3210);
      chk("post_reset_fv_once", 32'(fv_count - fv_base), 32'h1);

      // digit 0 recaptured (5 then 9) before the frame completes
      fv_base = fv_count;
      drive(4'hE, 7'h12, 8);
      drive(4'hE, 7'h10, 8);
      drive(4'hD, 7'h79, 8);
      drive(4'hB, 7'h24, 8);
      drive(4'h7, 7'h30, 8);
      drive(4'hF, 7'h7F, 6);
      chk("recap_value", 32'(value), 32'h3219);
      chk("recap_fv_once", 32'(fv_count - fv_base), 32'h1);

      // stability boundary: STABLE_CYCLES edges is too short, +1 captures
      drive(4'hE, 7'h40, 4);
      drive(4'hF, 7'h7F, 6);
      chk("short_hold_busy", 32'(busy), 32'h0);
      drive(4'hE, 7'h40, 5);
      drive(4'hF, 7'h7F, 6);
      chk("exact_hold_busy", 32'(busy), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
